rf_block_transfer_seq: RTL and testbench
========================================

Name: rf_block_transfer_seq

Overview:
- Multi-register load/store sequencer (LDM/STM class) for the CPU.
- Walks a 16-bit register list, lowest register first. Each register is one memory transfer over a req/ack handshake.
- STM reads registers through a register-file read port. LDM writes registers through the register-file write port.
- Optional base-register writeback. Register 15 is never written through the write port; it is reported on a separate PC-load interface.

Parameters:
- N, 4, register address width.
- M, 32, data/address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled only in IDLE.
- load  in  1  1 = LDM (memory to registers), 0 = STM (registers to memory).
- up  in  1  1 = increment-after, 0 = decrement-before.
- writeback  in  1  1 = update base register at end.
- base_reg  in  N  base register index.
- base_addr  in  M  base address value.
- reg_list  in  16  bit i set = transfer register i.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- rf_a1  out  N  register-file read address (STM).
- rf_rd1  in  M  register-file read data, combinational from rf_a1.
- rf_we3  out  1  register-file write enable.
- rf_a3  out  N  register-file write address.
- rf_wd3  out  M  register-file write data.
- pc_load  out  1  one-cycle pulse: register 15 loaded.
- pc_value  out  M  value for register 15.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  M  word address.
- mem_wdata  out  M  store data.
- mem_ack  in  1  transfer accepted/completed this cycle.
- mem_rdata  in  M  load data, valid with mem_ack.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0.
  - Captured list, address and count registers cleared.
  - An in-flight transfer is abandoned with no register write and no writeback.
- States: IDLE, SETUP, REQ, WB, DONE.
- IDLE:
  - On start=1, capture load, up, writeback, base_reg, base_addr, reg_list, and cnt = popcount(reg_list) (5 bits).
  - First address: up=1 gives base_addr; up=0 gives base_addr - 4*cnt.
  - Final base: base_addr +/- 4*cnt, modulo 2^M.
  - Go to SETUP. If reg_list=0, go to DONE instead: no memory traffic, no writeback.
- SETUP (1 cycle):
  - cur = index of lowest set bit of the remaining list; rf_a1 = cur.
  - At the edge: mem_addr = current address, mem_we = ~load, mem_wdata = rf_rd1 (STM; 0 for LDM), mem_req = 1. Go to REQ.
- REQ:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until an edge with mem_ack=1.
  - On the ack edge: clear bit cur, address += 4, mem_req = 0.
  - LDM, cur != 15: rf_we3 = 1, rf_a3 = cur, rf_wd3 = mem_rdata for exactly the next cycle.
  - LDM, cur == 15: pc_load = 1, pc_value = mem_rdata for the next cycle; rf_we3 stays 0.
  - Next state: SETUP if bits remain; else WB if writeback=1 and the base is not suppressed; else DONE.
- Base suppression: the base is suppressed when load=1 and reg_list[base_reg]=1. The loaded value wins.
- WB:
  - If base_reg != 15: at the edge, rf_we3 = 1, rf_a3 = base_reg, rf_wd3 = final base for the next cycle.
  - If base_reg == 15: pc_load pulses instead.
  - Go to DONE.
- DONE: done = 1 for one cycle; next state IDLE.
- busy = 1 from the cycle after accepted start through the DONE cycle inclusive.
- rf_we3 and pc_load are never high for more than one consecutive cycle per write. rf_we3 is 0 throughout an STM except the writeback cycle.
- start while busy is ignored. mem_ack while mem_req=0 is ignored.
- Address wrap-around is modulo 2^M with no error.
- Latency for k registers with 0-wait memory (ack in the first REQ cycle): 2k cycles of SETUP/REQ, then WB if used, then DONE.

Test Plan:
1. Reset mid-op:
   - Stimulus: STM list=0x000F, hold mem_ack=0, pull reset low in REQ, release, then start a 1-register STM.
   - Response: all outputs 0 immediately; no rf_we3 and no done from the aborted operation; the following STM completes normally.
2. LDM, no writeback:
   - Stimulus: list=0x0006, base=0x100, up=1, writeback=0, mem_rdata=0xAAAA then 0xBBBB, ack with one wait cycle each.
   - Response: reads at 0x100 and 0x104; R1=0xAAAA, R2=0xBBBB; single-cycle rf_we3 pulses; one done pulse.
3. STM, decrement-before with writeback:
   - Stimulus: list=0x4011, base_reg=13, base=0x200, up=0, writeback=1, rf returns 0x10+index.
   - Response: writes R0@0x1F4, R4@0x1F8, R14@0x1FC with data 0x10, 0x14, 0x1E; then rf_we3 for R13=0x1F4.
4. LDM including R15 and the base register:
   - Stimulus: list=0x8009, base_reg=3, writeback=1, base=0x0, mem_rdata=0x5, 0x7, 0x40.
   - Response: R0=5, R3=7 (no writeback), pc_load with pc_value=0x40, no rf_we3 to 15.
5. Empty list and start while busy:
   - Stimulus: start with list=0, then a second start during a 2-register op.
   - Response: done in the second cycle with no mem_req or rf_we3; the second start is ignored.
6. Wrap-around:
   - Stimulus: up=1, base=0xFFFFFFFC, list=0x0003, LDM.
   - Response: addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/rf_block_transfer_seq_if.sv
// Memory-side transfer bus of the multi-register load/store sequencer.
//   master : the sequencer (drives request, direction, address and store data)
//   slave  : the memory (returns ack and load data)
// mem_ack completes the pending request on the clock edge where it is high.
// mem_rdata is valid in the same cycle as mem_ack.
interface rf_block_transfer_seq_if #(
   parameter int M = 32
);
   logic         mem_req;
   logic         mem_we;
   logic [M-1:0] mem_addr;
   logic [M-1:0] mem_wdata;
   logic         mem_ack;
   logic [M-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );
endinterface

// File: rtl/rf_block_transfer_seq.sv
// Multi-register load/store (LDM/STM) sequencer.
// Walks a 16-bit register list from the lowest register upwards. Each listed
// register is moved by one memory transfer on the req/ack bus. Optionally the
// base register is written back with the final address.
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   start, load, up,      launch request plus operation attributes, sampled
//   writeback, base_reg,  only while idle
//   base_addr, reg_list
//   busy, done            operation in progress / one-cycle completion pulse
//   rf_a1, rf_rd1         register-file read port (store data source)
//   rf_we3, rf_a3, rf_wd3 register-file write port (loads and writeback)
//   pc_load, pc_value     one-cycle pulse when register 15 gets a new value
//   mem                   memory transfer bus (master side)
module rf_block_transfer_seq #(
   parameter int N = 4,
   parameter int M = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    load,
   input  logic                    up,
   input  logic                    writeback,
   input  logic [N-1:0]            base_reg,
   input  logic [M-1:0]            base_addr,
   input  logic [15:0]             reg_list,
   output logic                    busy,
   output logic                    done,
   output logic [N-1:0]            rf_a1,
   input  logic [M-1:0]            rf_rd1,
   output logic                    rf_we3,
   output logic [N-1:0]            rf_a3,
   output logic [M-1:0]            rf_wd3,
   output logic                    pc_load,
   output logic [M-1:0]            pc_value,
   rf_block_transfer_seq_if.master mem
);

   localparam logic [N-1:0] PC_IDX = N'(15);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_REQ,
      S_WB,
      S_DONE
   } state_t;

   state_t       state_q, state_d;
   logic [15:0]  list_q, list_d;
   logic [4:0]   cnt_q, cnt_d;
   logic [M-1:0] addr_q, addr_d;
   logic [M-1:0] final_q, final_d;
   logic         load_q, load_d;
   logic         wb_q, wb_d;
   logic [N-1:0] base_reg_q, base_reg_d;
   logic [N-1:0] cur_q, cur_d;

   logic         mem_req_q, mem_req_d;
   logic         mem_we_q, mem_we_d;
   logic [M-1:0] mem_addr_q, mem_addr_d;
   logic [M-1:0] mem_wdata_q, mem_wdata_d;
   logic         rf_we3_q, rf_we3_d;
   logic [N-1:0] rf_a3_q, rf_a3_d;
   logic [M-1:0] rf_wd3_q, rf_wd3_d;
   logic         pc_load_q, pc_load_d;
   logic [M-1:0] pc_value_q, pc_value_d;

   logic [4:0]   start_cnt;
   logic [M-1:0] start_span;
   logic [N-1:0] next_idx;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = '0;
      for (int i = 0; i < 16; i++) begin
         c = c + 5'(v[i]);
      end
      return c;
   endfunction

   // Scanning downwards leaves the lowest set index as the final value.
   function automatic logic [N-1:0] lowest_set(input logic [15:0] v);
      logic [N-1:0] idx;
      idx = '0;
      for (int i = 15; i >= 0; i--) begin
         if (v[i]) begin
            idx = N'(i);
         end
      end
      return idx;
   endfunction

   assign start_cnt  = popcount16(reg_list);
   assign start_span = M'({start_cnt, 2'b00});
   assign next_idx   = lowest_set(list_q);

   always_comb begin
      state_d     = state_q;
      list_d      = list_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      final_d     = final_q;
      load_d      = load_q;
      wb_d        = wb_q;
      base_reg_d  = base_reg_q;
      cur_d       = cur_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rf_we3_d    = 1'b0;
      rf_a3_d     = rf_a3_q;
      rf_wd3_d    = rf_wd3_q;
      pc_load_d   = 1'b0;
      pc_value_d  = pc_value_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               load_d     = load;
               // A loaded base register keeps the loaded value, so the
               // writeback is dropped up front.
               wb_d       = writeback & ~(load & reg_list[base_reg]);
               base_reg_d = base_reg;
               list_d     = reg_list;
               cnt_d      = start_cnt;
               // Decrement-before still walks upwards, starting from the
               // lowest address of the block.
               addr_d     = up ? base_addr : (base_addr - start_span);
               final_d    = up ? (base_addr + start_span) : (base_addr - start_span);
               state_d    = (reg_list == 16'h0000) ? S_DONE : S_SETUP;
            end
         end

         S_SETUP: begin
            cur_d       = next_idx;
            mem_req_d   = 1'b1;
            mem_we_d    = ~load_q;
            mem_addr_d  = addr_q;
            mem_wdata_d = load_q ? '0 : rf_rd1;
            state_d     = S_REQ;
         end

         S_REQ: begin
            if (mem.mem_ack) begin
               list_d    = list_q & ~(16'h0001 << cur_q);
               cnt_d     = cnt_q - 5'd1;
               addr_d    = addr_q + M'(4);
               mem_req_d = 1'b0;
               if (load_q) begin
                  if (cur_q == PC_IDX) begin
                     pc_load_d  = 1'b1;
                     pc_value_d = mem.mem_rdata;
                  end else begin
                     rf_we3_d = 1'b1;
                     rf_a3_d  = cur_q;
                     rf_wd3_d = mem.mem_rdata;
                  end
               end
               if (cnt_q != 5'd1) begin
                  state_d = S_SETUP;
               end else if (wb_q) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_DONE;
               end
            end
         end

         S_WB: begin
            if (base_reg_q == PC_IDX) begin
               pc_load_d  = 1'b1;
               pc_value_d = final_q;
            end else begin
               rf_we3_d = 1'b1;
               rf_a3_d  = base_reg_q;
               rf_wd3_d = final_q;
            end
            state_d = S_DONE;
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         list_q      <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         final_q     <= '0;
         load_q      <= 1'b0;
         wb_q        <= 1'b0;
         base_reg_q  <= '0;
         cur_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rf_we3_q    <= 1'b0;
         rf_a3_q     <= '0;
         rf_wd3_q    <= '0;
         pc_load_q   <= 1'b0;
         pc_value_q  <= '0;
      end else begin
         state_q     <= state_d;
         list_q      <= list_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         final_q     <= final_d;
         load_q      <= load_d;
         wb_q        <= wb_d;
         base_reg_q  <= base_reg_d;
         cur_q       <= cur_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rf_we3_q    <= rf_we3_d;
         rf_a3_q     <= rf_a3_d;
         rf_wd3_q    <= rf_wd3_d;
         pc_load_q   <= pc_load_d;
         pc_value_q  <= pc_value_d;
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign rf_a1         = (state_q == S_SETUP) ? next_idx : '0;
   assign rf_we3        = rf_we3_q;
   assign rf_a3         = rf_a3_q;
   assign rf_wd3        = rf_wd3_q;
   assign pc_load       = pc_load_q;
   assign pc_value      = pc_value_q;
   assign mem.mem_req   = mem_req_q;
   assign mem.mem_we    = mem_we_q;
   assign mem.mem_addr  = mem_addr_q;
   assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_rf_block_transfer_seq.sv
// Directed bench for rf_block_transfer_seq: a table of whole operations with
// hand-computed bus/register-file traffic, plus hand-written reset sequences.
module tb_rf_block_transfer_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        load;
   logic        up;
   logic        writeback;
   logic [3:0]  base_reg;
   logic [31:0] base_addr;
   logic [15:0] reg_list;
   logic        busy;
   logic        done;
   logic [3:0]  rf_a1;
   logic [31:0] rf_rd1;
   logic        rf_we3;
   logic [3:0]  rf_a3;
   logic [31:0] rf_wd3;
   logic        pc_load;
   logic [31:0] pc_value;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   rf_block_transfer_seq_if #(.M(32)) mem ();

   // Register file model: register i reads as 0x10 + i.
   assign rf_rd1 = 32'h10 + {28'h0, rf_a1};

   rf_block_transfer_seq #(.N(4), .M(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .load      (load),
      .up        (up),
      .writeback (writeback),
      .base_reg  (base_reg),
      .base_addr (base_addr),
      .reg_list  (reg_list),
      .busy      (busy),
      .done      (done),
      .rf_a1     (rf_a1),
      .rf_rd1    (rf_rd1),
      .rf_we3    (rf_we3),
      .rf_a3     (rf_a3),
      .rf_wd3    (rf_wd3),
      .pc_load   (pc_load),
      .pc_value  (pc_value),
      .mem       (mem)
   );

   typedef struct packed {
      logic             ld;
      logic             up;
      logic             wb;
      logic [3:0]       breg;
      logic [31:0]      base;
      logic [15:0]      list;
      int               ws;
      int               poke;
      logic [3:0][31:0] rd;
      int               n_mem;
      logic [3:0][31:0] e_addr;
      logic             e_we;
      logic [3:0][31:0] e_wd;
      int               n_rf;
      logic [3:0][3:0]  e_ra;
      logic [3:0][31:0] e_rd;
      int               n_pc;
      logic [31:0]      e_pc;
      int               cycles;
   } op_t;

   op_t ops [8];

   task automatic check(input string nm, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL op%0d %s: got 0x%h, expected 0x%h", k, nm, act, exp);
      end
   endtask

   task automatic check_outputs_zero(input int k);
      check("ctrl_zero", k, {26'h0, busy, done, rf_we3, pc_load, mem.mem_req, mem.mem_we}, 32'h0);
      check("addr_zero", k, {24'h0, rf_a1, rf_a3}, 32'h0);
      check("data_zero", k, rf_wd3 | pc_value | mem.mem_addr | mem.mem_wdata, 32'h0);
   endtask

   task automatic def(input int k, input logic ld, input logic u, input logic wb,
                      input logic [3:0] breg, input logic [31:0] base, input logic [15:0] list,
                      input int ws, input int poke, input int cycles);
      ops[k]        = '0;
      ops[k].ld     = ld;
      ops[k].up     = u;
      ops[k].wb     = wb;
      ops[k].breg   = breg;
      ops[k].base   = base;
      ops[k].list   = list;
      ops[k].ws     = ws;
      ops[k].poke   = poke;
      ops[k].cycles = cycles;
      ops[k].e_we   = ~ld;
   endtask

   // Runs one operation, acting as a memory with ws wait cycles per transfer,
   // and compares the observed traffic against table entry k.
   task automatic run_op(input int k);
      op_t         o;
      int          nmem, nrf, npc, wcnt, done_cyc, ndone;
      logic        busy_bad;
      logic [31:0] o_addr [4];
      logic [31:0] o_wd   [4];
      logic        o_we   [4];
      logic [3:0]  o_ra   [4];
      logic [31:0] o_rd   [4];
      logic [31:0] pcv;
      o = ops[k];
      nmem = 0; nrf = 0; npc = 0; wcnt = 0; done_cyc = 0; ndone = 0;
      busy_bad = 1'b0; pcv = '0;
      for (int i = 0; i < 4; i++) begin
         o_addr[i] = '0; o_wd[i] = '0; o_we[i] = 1'b0; o_ra[i] = '0; o_rd[i] = '0;
      end
      load = o.ld; up = o.up; writeback = o.wb; base_reg = o.breg;
      base_addr = o.base; reg_list = o.list; start = 1'b1;
      for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
         @(negedge clk);
         // Inputs change after launch; only the captured values may matter.
         start     = (cyc == o.poke);
         load      = ~o.ld;
         up        = ~o.up;
         writeback = ~o.wb;
         base_addr = 32'hDEAD_BEE0;
         reg_list  = 16'hFFFF;
         if (!busy) busy_bad = 1'b1;
         if (rf_we3) begin
            if (nrf < 4) begin o_ra[nrf] = rf_a3; o_rd[nrf] = rf_wd3; end
            nrf++;
         end
         if (pc_load) begin pcv = pc_value; npc++; end
         if (mem.mem_req) begin
            if (wcnt == o.ws) begin
               mem.mem_ack   = 1'b1;
               mem.mem_rdata = o.rd[nmem % 4];
               if (nmem < 4) begin
                  o_addr[nmem] = mem.mem_addr;
                  o_we[nmem]   = mem.mem_we;
                  o_wd[nmem]   = mem.mem_wdata;
               end
               nmem++;
               wcnt = 0;
            end else begin
               mem.mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            mem.mem_ack   = 1'b0;
            mem.mem_rdata = 32'h0;
            wcnt = 0;
         end
         if (done) begin ndone++; done_cyc = cyc; end
      end
      start = 1'b0;
      @(negedge clk);
      mem.mem_ack = 1'b0;
      check("cycles_to_done", k, done_cyc, o.cycles);
      check("done_count", k, ndone, 1);
      check("busy_during", k, {31'h0, busy_bad}, 32'h0);
      check("busy_after", k, {31'h0, busy}, 32'h0);
      check("done_after", k, {31'h0, done}, 32'h0);
      check("n_mem", k, nmem, o.n_mem);
      for (int i = 0; i < o.n_mem && i < 4; i++) begin
         check($sformatf("mem_addr[%0d]", i), k, o_addr[i], o.e_addr[i]);
         check($sformatf("mem_we[%0d]", i), k, {31'h0, o_we[i]}, {31'h0, o.e_we});
         check($sformatf("mem_wdata[%0d]", i), k, o_wd[i], o.e_wd[i]);
      end
      check("n_rf_writes", k, nrf, o.n_rf);
      for (int i = 0; i < o.n_rf && i < 4; i++) begin
         check($sformatf("rf_a3[%0d]", i), k, {28'h0, o_ra[i]}, {28'h0, o.e_ra[i]});
         check($sformatf("rf_wd3[%0d]", i), k, o_rd[i], o.e_rd[i]);
      end
      check("n_pc_load", k, npc, o.n_pc);
      if (o.n_pc > 0) check("pc_value", k, pcv, o.e_pc);
   endtask

   initial begin
      logic aborted_bad;

      // LDM R1,R2 from 0x100, one wait state per transfer, no writeback.
      def(0, 1'b1, 1'b1, 1'b0, 4'd5, 32'h100, 16'h0006, 1, 0, 7);
      ops[0].rd     = {32'h0, 32'h0, 32'hBBBB, 32'hAAAA};
      ops[0].n_mem  = 2;
      ops[0].e_addr = {32'h0, 32'h0, 32'h104, 32'h100};
      ops[0].n_rf   = 2;
      ops[0].e_ra   = {4'h0, 4'h0, 4'h2, 4'h1};
      ops[0].e_rd   = {32'h0, 32'h0, 32'hBBBB, 32'hAAAA};
      // STM decrement-before R0,R4,R14 base R13=0x200 with writeback.
      def(1, 1'b0, 1'b0, 1'b1, 4'd13, 32'h200, 16'h4011, 0, 0, 8);
      ops[1].n_mem  = 3;
      ops[1].e_addr = {32'h0, 32'h1FC, 32'h1F8, 32'h1F4};
      ops[1].e_wd   = {32'h0, 32'h1E, 32'h14, 32'h10};
      ops[1].n_rf   = 1;
      ops[1].e_ra   = {4'h0, 4'h0, 4'h0, 4'hD};
      ops[1].e_rd   = {32'h0, 32'h0, 32'h0, 32'h1F4};
      // LDM R0,R3,R15 with base R3 in the list: loaded value wins.
      def(2, 1'b1, 1'b1, 1'b1, 4'd3, 32'h0, 16'h8009, 0, 0, 7);
      ops[2].rd     = {32'h0, 32'h40, 32'h7, 32'h5};
      ops[2].n_mem  = 3;
      ops[2].e_addr = {32'h0, 32'h8, 32'h4, 32'h0};
      ops[2].n_rf   = 2;
      ops[2].e_ra   = {4'h0, 4'h0, 4'h3, 4'h0};
      ops[2].e_rd   = {32'h0, 32'h0, 32'h7, 32'h5};
      ops[2].n_pc   = 1;
      ops[2].e_pc   = 32'h40;
      // Empty list: straight to done, no traffic and no writeback.
      def(3, 1'b1, 1'b1, 1'b1, 4'd0, 32'h80, 16'h0000, 0, 0, 1);
      // Address wrap plus a start pulse while busy.
      def(4, 1'b1, 1'b1, 1'b0, 4'd9, 32'hFFFF_FFFC, 16'h0003, 0, 2, 5);
      ops[4].rd     = {32'h0, 32'h0, 32'h22, 32'h11};
      ops[4].n_mem  = 2;
      ops[4].e_addr = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC};
      ops[4].n_rf   = 2;
      ops[4].e_ra   = {4'h0, 4'h0, 4'h1, 4'h0};
      ops[4].e_rd   = {32'h0, 32'h0, 32'h22, 32'h11};
      // STM R1,R5 with base R15: writeback goes out as a PC load.
      def(5, 1'b0, 1'b1, 1'b1, 4'd15, 32'h1000, 16'h0022, 2, 0, 10);
      ops[5].n_mem  = 2;
      ops[5].e_addr = {32'h0, 32'h0, 32'h1004, 32'h1000};
      ops[5].e_wd   = {32'h0, 32'h0, 32'h15, 32'h11};
      ops[5].n_pc   = 1;
      ops[5].e_pc   = 32'h1008;
      // LDM decrement-before R0,R8 with base R2 writeback.
      def(6, 1'b1, 1'b0, 1'b1, 4'd2, 32'h50, 16'h0101, 0, 0, 6);
      ops[6].rd     = {32'h0, 32'h0, 32'hA2, 32'hA1};
      ops[6].n_mem  = 2;
      ops[6].e_addr = {32'h0, 32'h0, 32'h4C, 32'h48};
      ops[6].n_rf   = 3;
      ops[6].e_ra   = {4'h0, 4'h2, 4'h8, 4'h0};
      ops[6].e_rd   = {32'h0, 32'h48, 32'hA2, 32'hA1};
      // Single-register STM R7 used after the aborted operation.
      def(7, 1'b0, 1'b1, 1'b0, 4'd0, 32'h400, 16'h0080, 0, 0, 3);
      ops[7].n_mem  = 1;
      ops[7].e_addr = {32'h0, 32'h0, 32'h0, 32'h400};
      ops[7].e_wd   = {32'h0, 32'h0, 32'h0, 32'h17};

      reset = 1'b0; start = 1'b0; load = 1'b0; up = 1'b0; writeback = 1'b0;
      base_reg = '0; base_addr = '0; reg_list = '0;
      mem.mem_ack = 1'b0; mem.mem_rdata = '0;
      repeat (2) @(negedge clk);
      check_outputs_zero(100);
      reset = 1'b1;
      @(negedge clk);

      // Reset in the middle of a stalled STM.
      load = 1'b0; up = 1'b1; writeback = 1'b1; base_reg = 4'd13;
      base_addr = 32'h300; reg_list = 16'h000F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("req_first", 101, {31'h0, mem.mem_req}, 32'h1);
      check("addr_first", 101, mem.mem_addr, 32'h300);
      @(negedge clk);
      check("req_held", 101, {31'h0, mem.mem_req}, 32'h1);
      check("addr_held", 101, mem.mem_addr, 32'h300);
      check("we_held", 101, {31'h0, mem.mem_we}, 32'h1);
      check("wdata_held", 101, mem.mem_wdata, 32'h10);
      #2 reset = 1'b0;
      #1 check_outputs_zero(101);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      aborted_bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (rf_we3 || done || busy || mem.mem_req || pc_load) aborted_bad = 1'b1;
      end
      check("aborted_quiet", 101, {31'h0, aborted_bad}, 32'h0);
      run_op(7);

      for (int k = 0; k < 7; k++) begin
         run_op(k);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
